// File: rtl/agen_lsu_arbiter_pkg.sv
// Shared core types for the AGEN -> LSU path.
package agen_lsu_arbiter_pkg;

   // Default number of AGEN lanes feeding the LSU port.
   localparam int LSU_PORT_LANES = 2;

   // Memory packet handed from AGEN to the LSU; valid qualifies the rest.
   typedef struct packed {
      logic        valid;
      logic [3:0]  op;
      logic [7:0]  tag;
      logic [31:0] addr;
   } memPkt;

endpackage

// File: rtl/agen_lsu_rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr, with wrap.
module agen_lsu_rr_pick #(
   parameter int N = 2,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] winner
);

   int idx;

   // Scan upward from ptr; the first hit wins and later hits are ignored.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && valid[idx]) begin
            found  = 1'b1;
            winner = W'(idx);
         end
      end
   end

endmodule

// File: rtl/agen_lsu_arbiter.sv
// Round-robin arbiter of NUM_REQ AGEN lanes onto the single LSU input port.
// Each lane has a one-entry holding buffer; the output is a registered packet.
module agen_lsu_arbiter
   import agen_lsu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = LSU_PORT_LANES,
   parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_i,
   input  logic [NUM_REQ-1:0]  req_valid_i,
   input  memPkt [NUM_REQ-1:0] req_pkt_i,
   output logic [NUM_REQ-1:0]  req_ready_o,
   input  logic                lsu_ready_i,
   output memPkt               memPacket_o,
   output logic [GW-1:0]       grant_o
);

   memPkt [NUM_REQ-1:0] lane_buf;
   logic  [NUM_REQ-1:0] buf_valid;
   logic  [NUM_REQ-1:0] drain;
   memPkt               mem_q;
   memPkt               win_pkt;
   logic  [GW-1:0]      grant_q;
   logic  [GW-1:0]      rr_ptr;
   logic  [GW-1:0]      winner;
   logic                found;
   logic                out_en;

   // Output register may load when empty or when the LSU takes it.
   assign out_en = ~mem_q.valid | lsu_ready_i;

   agen_lsu_rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
      .valid  (buf_valid),
      .ptr    (rr_ptr),
      .found  (found),
      .winner (winner)
   );

   // Winner's buffer drains only when the output register actually loads.
   always_comb begin
      drain = '0;
      if (out_en && found) drain[winner] = 1'b1;
   end

   // A lane may refill in the same cycle its buffer drains (bypass of drain).
   assign req_ready_o = (reset || flush_i) ? '0 : (~buf_valid | drain);

   // Winning packet with valid forced; the incoming valid bit is ignored.
   always_comb begin
      win_pkt       = lane_buf[winner];
      win_pkt.valid = 1'b1;
   end

   // Lane holding buffers: refill takes priority over drain so a packet
   // arriving in the drain cycle keeps buf_valid set.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         buf_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
               lane_buf[i]  <= req_pkt_i[i];
               buf_valid[i] <= 1'b1;
            end else if (drain[i]) begin
               buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Output register, grant and round-robin pointer; flush keeps rr_ptr.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '0;
         grant_q <= '0;
         rr_ptr  <= '0;
      end else if (flush_i) begin
         mem_q   <= '0;
         grant_q <= '0;
      end else if (out_en) begin
         if (found) begin
            mem_q   <= win_pkt;
            grant_q <= winner;
            rr_ptr  <= (winner == GW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end else begin
            mem_q   <= '0;
         end
      end
   end

   assign memPacket_o = mem_q;
   assign grant_o     = grant_q;

endmodule

// File: tb/tb_agen_lsu_arbiter.sv
// Directed bench for agen_lsu_arbiter: NUM_REQ=2 and NUM_REQ=3 instances.
module tb_agen_lsu_arbiter;
   import agen_lsu_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush2, flush3;
   logic [1:0] v2, rdy2;
   memPkt [1:0] pkt2;
   logic       lsu2;
   memPkt      mem2;
   logic       gnt2;
   logic [2:0] v3, rdy3;
   memPkt [2:0] pkt3;
   logic       lsu3;
   memPkt      mem3;
   logic [1:0] gnt3;

   int n_chk  = 0;
   int n_pass = 0;
   int k0, k1;
   logic [1:0] x;

   always #5 clk = ~clk;

   agen_lsu_arbiter #(.NUM_REQ(2)) u_dut2 (
      .clk(clk), .reset(reset), .flush_i(flush2), .req_valid_i(v2),
      .req_pkt_i(pkt2), .req_ready_o(rdy2), .lsu_ready_i(lsu2),
      .memPacket_o(mem2), .grant_o(gnt2)
   );

   agen_lsu_arbiter #(.NUM_REQ(3)) u_dut3 (
      .clk(clk), .reset(reset), .flush_i(flush3), .req_valid_i(v3),
      .req_pkt_i(pkt3), .req_ready_o(rdy3), .lsu_ready_i(lsu3),
      .memPacket_o(mem3), .grant_o(gnt3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane packet as offered by AGEN (inner valid bit deliberately left 0).
   function automatic memPkt mk(input int lane, input int k);
      memPkt p;
      p       = '0;
      p.addr  = 32'hA000_0000 | 32'(lane << 8) | 32'(k);
      p.tag   = 8'(lane * 16 + k);
      p.op    = 4'(k);
      return p;
   endfunction

   // Same packet as it must appear on the LSU port.
   function automatic memPkt ex(input memPkt p);
      memPkt q;
      q       = p;
      q.valid = 1'b1;
      return q;
   endfunction

   initial begin
      reset = 1'b1; flush2 = 1'b0; flush3 = 1'b0;
      v2 = '0; pkt2 = '0; lsu2 = 1'b1;
      v3 = '0; pkt3 = '0; lsu3 = 1'b1;
      tick(); tick();
      chk("rst_mem", 64'(mem2), 64'(0));
      chk("rst_gnt", 64'(gnt2), 64'(0));
      chk("rst_rdy", 64'(rdy2), 64'(0));
      chk("rst_mem3", 64'(mem3), 64'(0));
      reset = 1'b0; #1;
      chk("rel_rdy", 64'(rdy2), 64'(2'b11));
      chk("rel_rdy3", 64'(rdy3), 64'(3'b111));

      // Fairness: both lanes always valid, alternate grants and readies.
      v2 = 2'b11; k0 = 0; k1 = 0;
      for (int c = 1; c <= 8; c++) begin
         pkt2[0] = mk(0, k0); pkt2[1] = mk(1, k1); #1;
         chk("fair_rdy", 64'(rdy2), 64'((c == 1) ? 2'b11 : ((c % 2 == 0) ? 2'b01 : 2'b10)));
         x = v2 & rdy2;
         tick();
         if (x[0]) k0++;
         if (x[1]) k1++;
         if (c >= 2) begin
            chk("fair_out", 64'(mem2), 64'(ex(mk((c - 2) % 2, (c - 2) / 2))));
            chk("fair_gnt", 64'(gnt2), 64'((c - 2) % 2));
         end
      end

      // Backpressure: hold L0_3 while both buffers are full.
      lsu2 = 1'b0; pkt2[0] = mk(0, 5); pkt2[1] = mk(1, 4); #1;
      chk("bp_rdy0", 64'(rdy2), 64'(0));
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("bp_mem", 64'(mem2), 64'(ex(mk(0, 3))));
         chk("bp_gnt", 64'(gnt2), 64'(0));
         chk("bp_rdy", 64'(rdy2), 64'(0));
      end
      v2 = 2'b00; lsu2 = 1'b1;
      tick();
      chk("bp_next", 64'(mem2), 64'(ex(mk(1, 3))));
      chk("bp_ngnt", 64'(gnt2), 64'(1));
      tick();
      chk("bp_last", 64'(mem2), 64'(ex(mk(0, 4))));

      // Flush with both buffers full, output valid, lane 1 offering; rr_ptr=1.
      lsu2 = 1'b0; v2 = 2'b11; pkt2[0] = mk(0, 5); pkt2[1] = mk(1, 5); #1;
      chk("fl_fill_rdy", 64'(rdy2), 64'(2'b11));
      tick();
      chk("fl_hold", 64'(mem2), 64'(ex(mk(0, 4))));
      flush2 = 1'b1; v2 = 2'b10; pkt2[1] = mk(1, 6); lsu2 = 1'b1; #1;
      chk("fl_rdy", 64'(rdy2), 64'(0));
      tick();
      flush2 = 1'b0; v2 = 2'b00; #1;
      chk("fl_mem", 64'(mem2), 64'(0));
      chk("fl_gnt", 64'(gnt2), 64'(0));
      chk("fl_empty", 64'(rdy2), 64'(2'b11));
      tick();
      chk("fl_drop", 64'(mem2), 64'(0));
      v2 = 2'b11; pkt2[0] = mk(0, 7); pkt2[1] = mk(1, 7);
      tick();
      v2 = 2'b00;
      tick();
      chk("fl_rr_mem", 64'(mem2), 64'(ex(mk(1, 7))));
      chk("fl_rr_gnt", 64'(gnt2), 64'(1));
      tick();
      chk("fl_rr_mem2", 64'(mem2), 64'(ex(mk(0, 7))));
      chk("fl_rr_gnt2", 64'(gnt2), 64'(0));

      // Reset with traffic pending; rr_ptr is 1 beforehand.
      v2 = 2'b11; pkt2[0] = mk(0, 8); pkt2[1] = mk(1, 8);
      tick();
      tick();
      chk("mr_pre", 64'(mem2), 64'(ex(mk(1, 8))));
      reset = 1'b1; #1;
      chk("mr_rdy_c", 64'(rdy2), 64'(0));
      tick();
      chk("mr_mem", 64'(mem2), 64'(0));
      chk("mr_gnt", 64'(gnt2), 64'(0));
      chk("mr_rdy", 64'(rdy2), 64'(0));
      reset = 1'b0; pkt2[0] = mk(0, 9); pkt2[1] = mk(1, 9); #1;
      chk("mr_rel_rdy", 64'(rdy2), 64'(2'b11));
      tick();
      v2 = 2'b00;
      tick();
      chk("mr_first", 64'(mem2), 64'(ex(mk(0, 9))));
      chk("mr_fgnt", 64'(gnt2), 64'(0));
      tick();
      chk("mr_second", 64'(mem2), 64'(ex(mk(1, 9))));

      // Single lane streaming A, B, C.
      v2 = 2'b01; pkt2[0] = mk(0, 10); #1;
      chk("sl_rdyA", 64'(rdy2[0]), 64'(1));
      tick();
      pkt2[0] = mk(0, 11); #1;
      chk("sl_rdyB", 64'(rdy2[0]), 64'(1));
      tick();
      chk("sl_A", 64'(mem2), 64'(ex(mk(0, 10))));
      pkt2[0] = mk(0, 12); #1;
      chk("sl_rdyC", 64'(rdy2[0]), 64'(1));
      tick();
      chk("sl_B", 64'(mem2), 64'(ex(mk(0, 11))));
      v2 = 2'b00;
      tick();
      chk("sl_C", 64'(mem2), 64'(ex(mk(0, 12))));
      chk("sl_gnt", 64'(gnt2), 64'(0));
      tick();
      chk("sl_idle", 64'(mem2), 64'(0));

      // NUM_REQ=3 wrap-around: lane 1 alone sets rr_ptr=2.
      v3 = 3'b010; pkt3[1] = mk(1, 20);
      tick();
      v3 = 3'b000;
      tick();
      chk("w3_l1", 64'(mem3), 64'(ex(mk(1, 20))));
      chk("w3_g1", 64'(gnt3), 64'(1));
      tick();
      chk("w3_idle", 64'(mem3), 64'(0));
      v3 = 3'b011; pkt3[0] = mk(0, 21); pkt3[1] = mk(1, 21);
      tick();
      v3 = 3'b000;
      tick();
      chk("w3_a_g", 64'(gnt3), 64'(0));
      chk("w3_a_m", 64'(mem3), 64'(ex(mk(0, 21))));
      tick();
      chk("w3_b_g", 64'(gnt3), 64'(1));
      chk("w3_b_m", 64'(mem3), 64'(ex(mk(1, 21))));
      // Lane 0 alone moves rr_ptr to 1.
      v3 = 3'b001; pkt3[0] = mk(0, 22);
      tick();
      v3 = 3'b000;
      tick();
      chk("w3_l0", 64'(gnt3), 64'(0));
      v3 = 3'b101; pkt3[0] = mk(0, 23); pkt3[2] = mk(2, 23);
      tick();
      v3 = 3'b000;
      tick();
      chk("w3_c_g", 64'(gnt3), 64'(2));
      chk("w3_c_m", 64'(mem3), 64'(ex(mk(2, 23))));
      tick();
      chk("w3_d_g", 64'(gnt3), 64'(0));
      chk("w3_d_m", 64'(mem3), 64'(ex(mk(0, 23))));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/agen_lsu_arbiter.md
# agen_lsu_arbiter

Arbitrates the single load-store-unit input port between NUM_REQ address-generation lanes. Each lane presents a memPkt with a valid/ready handshake; the block buffers one packet per lane, picks a winner round-robin, and drives a registered memPkt to the LSU under LSU backpressure. It sits between the AGEN stage outputs and the LSU. It replaces the single-lane AGEN→LSU pipeline register when more than one memory pipe is configured.

## Interface
- NUM_REQ, 2: number of AGEN lanes competing for the LSU port (2–4).
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush_i  in  1  pipeline flush; discards every in-flight packet
- req_valid_i  in  NUM_REQ  lane i presents a packet
- req_pkt_i  in  NUM_REQ x memPkt  lane packets
- req_ready_o  out  NUM_REQ  lane i may hand over a packet this cycle
- lsu_ready_i  in  1  LSU accepts memPacket_o this cycle
- memPacket_o  out  memPkt  registered packet to LSU; memPacket_o.valid qualifies it
- grant_o  out  clog2(NUM_REQ)  lane index of the packet currently in memPacket_o

## Operation
- Per-lane holding buffer: one memPkt plus buf_valid[i].
- A lane transfer occurs when req_valid_i[i] & req_ready_o[i]. The packet is written to buf[i] and buf_valid[i] is set.
- req_ready_o[i] = ~buf_valid[i] | drain[i]. This is a combinational bypass of the drain. It is forced to 0 while reset or flush_i is high.
- Output load enable: out_en = ~memPacket_o.valid | lsu_ready_i.
- Arbitration: when out_en is high and any buf_valid is set, pick the first valid lane at or after rr_ptr, scanning upward with wrap-around.
  - The winner's buffer drains (drain[w]=1).
  - memPacket_o <= buf[w] with valid=1, and grant_o <= w.
  - rr_ptr <= (w+1) mod NUM_REQ.
- When out_en is high and no buffer is valid, memPacket_o.valid <= 0. The other packet fields are zeroed.
- When out_en is low, memPacket_o, grant_o and rr_ptr hold. No buffer drains.
- Incoming packets never bypass their lane buffer straight to the output.
- The memPacket_o.valid field is authoritative; the arbiter ignores the valid bit inside req_pkt_i.
- Flush (flush_i high): clears buf_valid, memPacket_o and grant_o to 0. rr_ptr holds. Flush overrides any transfer or drain in the same cycle; a packet offered that cycle is dropped.
- Reset: same as flush, and additionally rr_ptr <= 0.
- Simultaneous drain and refill of one lane in the same cycle is legal. The new packet lands in buf[i] and buf_valid[i] stays set.

## Timing
- Minimum latency is 2 cycles: a transfer at edge N makes buf valid after N, and memPacket_o is valid after edge N+1.
- Sustained throughput is one packet per cycle to the LSU while lsu_ready_i=1.
- Each lane can sustain one packet per cycle only when it wins every cycle, i.e. when it is the sole active lane.
- Fairness: with all lanes continuously valid and lsu_ready_i=1, grants rotate 0,1,…,NUM_REQ-1,0.
- A waiting lane is granted within NUM_REQ output slots.
- Reset values: memPacket_o=0, grant_o=0, req_ready_o=0 while reset is high. After reset deasserts, req_ready_o is all ones.

## Structure
- memPkt type and the LSU_PORT_LANES default belong in the shared core package. The arbiter adds no new typedefs.
- One sub-module: agen_lsu_rr_pick. It is combinational: it takes the valid vector and the pointer, and returns found and winner. It is reusable by other round-robin ports.
- The lane buffers and output register are inline in agen_lsu_arbiter.

## Test plan
- Single lane, NUM_REQ=2, lsu_ready_i=1: lane 0 sends packets A, B, C on consecutive cycles. memPacket_o shows A, B, C two cycles after each transfer, grant_o=0, and req_ready_o[0] stays 1.
- Both lanes continuously valid with packets L0_k and L1_k, lsu_ready_i=1: the output sequence is L0_0, L1_0, L0_1, L1_1, …; each lane's ready toggles 1,0 in alternate cycles.
- Backpressure: memPacket_o holds packet P with lsu_ready_i=0 for 3 cycles while both buffers are full. memPacket_o and grant_o are stable and req_ready_o=00. When lsu_ready_i rises, the next winner loads in the following cycle.
- Flush mid-stream: both buffers are full, the output is valid, and lane 1 transfers in the flush cycle. The next cycle shows memPacket_o.valid=0, all buffers empty, and the lane 1 packet is never emitted. rr_ptr is unchanged, as checked by the next grant order.
- Reset mid-operation: assert reset with traffic pending. All outputs are 0 and req_ready_o=0 during reset. After release, the first contested grant goes to lane 0.
- NUM_REQ=3 wrap-around: rr_ptr=2 with only lanes 0 and 1 valid gives grant order 0, 1. With lanes 2 and 0 valid at rr_ptr=1, the order is 2, 0.
